keypad_entry: RTL

Keypad input front end for the MCU board: it scans a 4x4 hex keypad, debounces it, and assembles up to four digits into a 16-bit value. It is the input counterpart of the seven-segment display path. `DIGITS` feeds the display while the user types. On ENTER, `KEY_VAL` delivers the entry to the MCU's input port, either as raw hex or as a decimal entry converted from BCD to binary.

---
 rtl/keypad_entry_pkg.sv | 25 ++
 rtl/keypad_entry_if.sv | 27 ++
 rtl/keypad_entry_bcd_to_bin.sv | 15 +
 rtl/keypad_entry.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the keypad entry front end.
// No logic; consumed by keypad_entry and its bench.
// No flow control involved.
package keypad_pkg;

  // Debounce states for one accepted key
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } db_state_t;

  // Key codes by [column][row], row 0 is the top row
  localparam logic [0:3][0:3][3:0] KEY_MAP = 64'h1470_258F_369E_ABCD;

  // Autorepeat: first repeat after this many full scans, then every AUTOREP_NEXT
  localparam int AUTOREP_FIRST = 128;
  localparam int AUTOREP_NEXT  = 32;

  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    return KEY_MAP[col][row];
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad pins plus MCU-facing entry outputs, bundled for keypad_entry.
// Pure wiring, no latency.
// No backpressure: all outputs are pulses or levels.
interface keypad_entry_if;
  logic        MODE;
  logic [3:0]  ROWS;
  logic        ENTER;
  logic        CLR;
  logic [3:0]  COLS;
  logic [15:0] DIGITS;
  logic [3:0]  KEY_CODE;
  logic        KEY_STROBE;
  logic [15:0] KEY_VAL;
  logic        KEY_VALID;

  // Environment side: keypad and MCU controls
  modport master (
    output MODE, ROWS, ENTER, CLR,
    input  COLS, DIGITS, KEY_CODE, KEY_STROBE, KEY_VAL, KEY_VALID
  );

  // Keypad front end side
  modport slave (
    input  MODE, ROWS, ENTER, CLR,
    output COLS, DIGITS, KEY_CODE, KEY_STROBE, KEY_VAL, KEY_VALID
  );
endinterface

// File: rtl/keypad_entry_bcd_to_bin.sv
// Four-digit packed BCD to binary, 0..9999.
// Combinational, zero latency.
// No flow control.
module bcd_to_bin (
  input  logic [15:0] i_bcd,
  output logic [13:0] o_bin
);
  // Weighted sum of the four decimal digits
  always_comb begin
    o_bin = 14'(i_bcd[15:12]) * 14'd1000
          + 14'(i_bcd[11:8])  * 14'd100
          + 14'(i_bcd[7:4])   * 14'd10
          + 14'(i_bcd[3:0]);
  end
endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scan, debounce and 4-digit entry (hex or decimal) for the MCU.
// Accept within DEBOUNCE_SCANS..+1 full scans of a press; ENTER result 1 cycle after edge.
// No backpressure; optional autorepeat under KEYPAD_AUTOREPEAT_EN.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          CLK,
  input  logic          RST,
  keypad_entry_if.slave kp
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [3:0]    r_cols;
  logic [3:0]    r_rows_s1, r_rows_s2;
  logic [1:0]    r_scan_hits;
  logic [3:0]    r_scan_code;
  db_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_db_cnt, w_db_cnt_nxt;
  logic [3:0]    r_db_key, w_db_key_nxt;
  logic          r_enter_d, r_clr_d, r_mode_d;
  logic [15:0]   r_digits, r_val;
  logic [3:0]    r_code;
  logic          r_strobe, r_valid;

  logic          w_last, w_scan_done, w_single, w_accept, w_acc_ok;
  logic [2:0]    w_col_hits, w_sum;
  logic [1:0]    w_col_row, w_sum_sat;
  logic [3:0]    w_code;
  logic          w_enter_rise, w_clr_rise, w_mode_chg;
  logic [13:0]   w_bin;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [7:0]    r_rep_cnt, w_rep_cnt_nxt;
  logic          r_rep_first, w_rep_first_nxt;
`endif

  assign w_last      = (r_dwell == DW'(SCAN_CYCLES - 1));
  assign w_scan_done = w_last && (r_col == 2'd3);

  // Column dwell counter and one-hot-low column drive, wrapping 3->0 without a gap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dwell <= '0;
      r_col   <= 2'd0;
      r_cols  <= 4'b1110;
    end else if (w_last) begin
      r_dwell <= '0;
      r_col   <= r_col + 2'd1;
      r_cols  <= ~(4'b0001 << (r_col + 2'd1));
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rows_s1 <= 4'hF;
      r_rows_s2 <= 4'hF;
    end else begin
      r_rows_s1 <= kp.ROWS;
      r_rows_s2 <= r_rows_s1;
    end
  end

  // Classify the current column sample and fold it into the running scan result
  always_comb begin
    w_col_hits = 3'd0;
    w_col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!r_rows_s2[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_row  = 2'(r);
      end
    end
    w_sum     = {1'b0, r_scan_hits} + w_col_hits;
    w_sum_sat = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_code    = (w_col_hits != 3'd0) ? key_lookup(r_col, w_col_row) : r_scan_code;
    w_single  = (w_sum == 3'd1);
  end

  // Scan accumulator: hit count saturates at 2 so multi-key scans read as none
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_scan_hits <= 2'd0;
      r_scan_code <= 4'd0;
    end else if (w_last) begin
      r_scan_hits <= (r_col == 2'd3) ? 2'd0 : w_sum_sat;
      r_scan_code <= (r_col == 2'd3) ? 4'd0 : w_code;
    end
  end

  // Debounce next-state; counts scans after the first sighting, so accept lands D..D+1 scans after press
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_db_key_nxt = r_db_key;
    w_accept     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_first_nxt = r_rep_first;
`endif
    if (w_scan_done) begin
      case (r_state)
        IDLE: begin
          if (w_single) begin
            w_state_nxt  = PRESS_PEND;
            w_db_cnt_nxt = '0;
            w_db_key_nxt = w_code;
          end
        end
        PRESS_PEND: begin
          if (!w_single) begin
            w_state_nxt = IDLE;
          end else if (w_code != r_db_key) begin
            w_db_key_nxt = w_code;
            w_db_cnt_nxt = '0;
          end else if (r_db_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
            w_state_nxt  = HELD;
            w_db_cnt_nxt = '0;
            w_accept     = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_cnt_nxt   = 8'd0;
            w_rep_first_nxt = 1'b1;
`endif
          end else begin
            w_db_cnt_nxt = r_db_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!w_single) begin
            w_state_nxt  = REL_PEND;
            w_db_cnt_nxt = '0;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if ((r_rep_cnt + 8'd1) == (r_rep_first ? 8'(AUTOREP_FIRST) : 8'(AUTOREP_NEXT))) begin
              w_accept        = 1'b1;
              w_rep_cnt_nxt   = 8'd0;
              w_rep_first_nxt = 1'b0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 8'd1;
            end
`endif
          end
        end
        REL_PEND: begin
          if (w_single) begin
            w_state_nxt = HELD;
          end else if (r_db_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
            w_state_nxt = IDLE;
          end else begin
            w_db_cnt_nxt = r_db_cnt + CW'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Debounce state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_db_cnt <= '0;
      r_db_key <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
      r_db_key <= w_db_key_nxt;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Repeat interval counter, only meaningful while HELD
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rep_cnt   <= 8'd0;
      r_rep_first <= 1'b1;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_first <= w_rep_first_nxt;
    end
  end
`endif

  bcd_to_bin u_bcd_to_bin (
    .i_bcd (r_digits),
    .o_bin (w_bin)
  );

  assign w_enter_rise = kp.ENTER & ~r_enter_d;
  assign w_clr_rise   = kp.CLR & ~r_clr_d;
  assign w_mode_chg   = kp.MODE ^ r_mode_d;
  assign w_acc_ok     = w_accept && !(kp.MODE && (r_db_key > 4'd9));

  // Entry register: ENTER beats CLR/MODE clears, which beat a digit accept
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_enter_d <= 1'b0;
      r_clr_d   <= 1'b0;
      r_mode_d  <= 1'b0;
      r_digits  <= 16'h0;
      r_val     <= 16'h0;
      r_code    <= 4'd0;
      r_strobe  <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_enter_d <= kp.ENTER;
      r_clr_d   <= kp.CLR;
      r_mode_d  <= kp.MODE;
      r_strobe  <= 1'b0;
      r_valid   <= 1'b0;
      if (w_enter_rise) begin
        r_val    <= kp.MODE ? {2'b00, w_bin} : r_digits;
        r_valid  <= 1'b1;
        r_digits <= 16'h0;
      end else if (w_clr_rise || w_mode_chg) begin
        r_digits <= 16'h0;
      end else if (w_acc_ok) begin
        r_digits <= {r_digits[11:0], r_db_key};
        r_code   <= r_db_key;
        r_strobe <= 1'b1;
      end
    end
  end

  assign kp.COLS       = r_cols;
  assign kp.DIGITS     = r_digits;
  assign kp.KEY_CODE   = r_code;
  assign kp.KEY_STROBE = r_strobe;
  assign kp.KEY_VAL    = r_val;
  assign kp.KEY_VALID  = r_valid;

endmodule
